morse_key_timer: RTL

- Front end of the Morse texter; sits directly upstream of the texter control FSM.
- Synchronises and debounces the raw telegraph key into a clean `sw`.
- Runs a tick-prescaled duration counter that the control FSM restarts with `tm_reset`.
- Compares the elapsed time against two thresholds to produce `dash_dit` (dash-length press / character gap) and `space` (backspace-length press / word gap).

---
 rtl/morse_key_timer_pkg.sv | 17 +
 rtl/morse_key_timer_if.sv | 31 +++
 rtl/morse_key_timer_debounce.sv | 101 ++++++++++
 rtl/morse_key_timer.sv | 66 ++++++
 4 files changed

// File: rtl/morse_key_timer_pkg.sv
// Shared defaults and debounce state encoding for the Morse texter key front end.
package morse_pkg;

  localparam int unsigned DEB_CYCLES  = 4;
  localparam int unsigned TICK_DIV    = 1000;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DASH_TICKS  = 3;
  localparam int unsigned SPACE_TICKS = 7;

  typedef enum logic [1:0] {
    ST_LO = 2'd0,
    PD_HI = 2'd1,
    ST_HI = 2'd2,
    PD_LO = 2'd3
  } deb_state_e;

endpackage

// File: rtl/morse_key_timer_if.sv
// Key/timer signal bundle between the texter control FSM (master) and the key timer (slave).
interface morse_key_timer_if #(
  parameter int unsigned CNT_W = morse_pkg::CNT_W
) ();

  logic             key_raw;
  logic             tm_reset;
  logic             sw;
  logic             dash_dit;
  logic             space;
  logic [CNT_W-1:0] dur_cnt;

  modport master (
    output key_raw,
    output tm_reset,
    input  sw,
    input  dash_dit,
    input  space,
    input  dur_cnt
  );

  modport slave (
    input  key_raw,
    input  tm_reset,
    output sw,
    output dash_dit,
    output space,
    output dur_cnt
  );

endinterface

// File: rtl/morse_key_timer_debounce.sv
// Two-flop synchronizer plus a four-state debounce FSM producing a registered clean key level.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = morse_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic sw
);
  import morse_pkg::*;

  localparam int unsigned     CntW   = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            sync1_q;
  logic            key_s_q;
  deb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sw_q, sw_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
      state_q <= ST_LO;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      key_s_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LO: begin
        if (key_s_q) begin
          // A single-sample debounce commits on the first differing sample.
          if (CntMax == CntOne) begin
            state_d = ST_HI;
            cnt_d   = '0;
          end else begin
            state_d = PD_HI;
            cnt_d   = CntOne;
          end
        end
      end
      PD_HI: begin
        if (!key_s_q) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q + CntOne == CntMax) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      ST_HI: begin
        if (!key_s_q) begin
          if (CntMax == CntOne) begin
            state_d = ST_LO;
            cnt_d   = '0;
          end else begin
            state_d = PD_LO;
            cnt_d   = CntOne;
          end
        end
      end
      PD_LO: begin
        if (key_s_q) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q + CntOne == CntMax) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // sw is decoded from the next state so it changes on the committing edge.
  always_comb begin
    sw_d = (state_d == ST_HI) || (state_d == PD_LO);
  end

  assign sw = sw_q;

endmodule

// File: rtl/morse_key_timer.sv
// Morse texter front end: debounced key, tick-prescaled duration counter and dit/dash/space decode.
module morse_key_timer #(
  parameter int unsigned DEB_CYCLES  = morse_pkg::DEB_CYCLES,
  parameter int unsigned TICK_DIV    = morse_pkg::TICK_DIV,
  parameter int unsigned CNT_W       = morse_pkg::CNT_W,
  parameter int unsigned DASH_TICKS  = morse_pkg::DASH_TICKS,
  parameter int unsigned SPACE_TICKS = morse_pkg::SPACE_TICKS
) (
  input logic               clk,
  input logic               rst_n,
  morse_key_timer_if.slave  bus
);
  import morse_pkg::*;

  localparam int unsigned      PreW    = $clog2(TICK_DIV);
  localparam logic [PreW-1:0]  PreLast = PreW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DashThr = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] SpcThr  = CNT_W'(SPACE_TICKS);

  logic             sw;
  logic             tick;
  logic [PreW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] dur_cnt_q, dur_cnt_d;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(bus.key_raw),
    .sw     (sw)
  );

  assign tick = (pre_cnt_q == PreLast);

  // tm_reset wins over a coincident tick; the count saturates rather than wrapping.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    dur_cnt_d = dur_cnt_q;
    if (bus.tm_reset) begin
      pre_cnt_d = '0;
      dur_cnt_d = '0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PreW'(1);
      if (tick && (dur_cnt_q != '1)) begin
        dur_cnt_d = dur_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      dur_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      dur_cnt_q <= dur_cnt_d;
    end
  end

  assign bus.sw       = sw;
  assign bus.dur_cnt  = dur_cnt_q;
  assign bus.dash_dit = (dur_cnt_q >= DashThr);
  assign bus.space    = (dur_cnt_q >= SpcThr);

endmodule
